// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and IF/ID record for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } ifid_t;

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register for a fetch returned while IF/ID is stalled.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and
// drives the IF/ID register under HDU stall and ID-stage flush/redirect control.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            pc_write_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    output logic [PC_W-1:0] ifid_pc_o,
    output logic [31:0]     ifid_instr_o,
    output logic            ifid_valid_o
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
    ifid_t           ifid_q, ifid_d;

    logic            hold;
    logic            skid_load, skid_clear, skid_valid;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     skid_instr;
    ifid_t           bubble;

    assign hold = stall_i | ~pc_write_i;

    // A bubble keeps the last PC so downstream debug still sees where IF/ID was.
    always_comb begin
        bubble       = ifid_q;
        bubble.instr = NOP_INSTR;
        bubble.valid = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        ifid_d     = ifid_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (imem_ack_i) begin
                    if (flush_i || pend_q) begin
                        pc_d   = flush_i ? branch_target_i : pend_tgt_q;
                        pend_d = 1'b0;
                        ifid_d = bubble;
                    end else if (hold) begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        ifid_d.pc    = pc_q;
                        ifid_d.instr = imem_data_i;
                        ifid_d.valid = 1'b1;
                        pc_d         = pc_next(pc_q);
                    end
                end else if (flush_i) begin
                    // The outstanding request must keep its address; redirect once it acks.
                    pend_d     = 1'b1;
                    pend_tgt_d = branch_target_i;
                    ifid_d     = bubble;
                end else if (!hold) begin
                    ifid_d = bubble;
                end
            end

            ST_HOLD: begin
                if (flush_i) begin
                    skid_clear = 1'b1;
                    pc_d       = branch_target_i;
                    ifid_d     = bubble;
                    state_d    = ST_FETCH;
                end else if (!hold) begin
                    ifid_d.pc    = skid_pc;
                    ifid_d.instr = skid_instr;
                    ifid_d.valid = skid_valid;
                    skid_clear   = 1'b1;
                    pc_d         = pc_next(pc_q);
                    state_d      = ST_FETCH;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_tgt_q   <= '0;
            ifid_q.pc    <= '0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            ifid_q     <= ifid_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_data_i),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign imem_req_o   = (state_q == ST_FETCH);
    assign imem_addr_o  = pc_q;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_valid_o = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bench-driven memory, scoreboard of accepted fetches.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pc_write, stall, flush;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic [31:0] ifid_pc, ifid_instr;
    logic        ifid_valid;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start),
        .pc_write_i      (pc_write),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_target_i (target),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ack_i      (ack),
        .imem_data_i     (data),
        .ifid_pc_o       (ifid_pc),
        .ifid_instr_o    (ifid_instr),
        .ifid_valid_o    (ifid_valid)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc, last_pc, last_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a << 8) | 32'h0000_0067;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk(tag, {31'd0, ifid_valid}, 32'd0);
        chk(tag, ifid_instr, NOP);
        chk(tag, ifid_pc, last_pc);
    endtask

    task automatic chk_held(input string tag);
        chk(tag, {31'd0, ifid_valid}, 32'd1);
        chk(tag, ifid_instr, last_instr);
        chk(tag, ifid_pc, last_pc);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk(tag, {31'd0, req}, {31'd0, r});
        chk(tag, addr, a);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed pc %h", tag, ifid_pc);
        end else begin
            e = sb.pop_front();
            chk(tag, ifid_pc, e.pc);
            chk(tag, ifid_instr, e.instr);
            chk(tag, {31'd0, ifid_valid}, 32'd1);
            last_pc    = e.pc;
            last_instr = e.instr;
        end
    endtask

    task automatic accept(input string tag);
        chk_req(tag, 1'b1, exp_pc);
        ack  = 1'b1;
        data = instr_of(exp_pc);
        sb.push_back({exp_pc, instr_of(exp_pc)});
        tick();
        ack  = 1'b0;
        data = '0;
        pop_check(tag);
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic bubbles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk_req(tag, 1'b1, exp_pc);
            tick();
            chk_bubble(tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; pc_write = 1'b1; stall = 1'b0; flush = 1'b0;
        target = '0; ack = 1'b0; data = '0;
        exp_pc = '0; last_pc = '0; last_instr = '0;
        tick(); tick();

        // reset state
        chk_req("reset_req", 1'b0, 32'h0);
        chk_bubble("reset_ifid");
        rst_n = 1'b1;
        tick();
        chk_req("idle_no_req", 1'b0, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;

        // back-to-back fetch, dropping start_i has no effect
        for (int k = 0; k < 4; k++) accept("b2b");

        // three-cycle memory latency
        bubbles(2, "lat3_bubble");
        accept("lat3");
        bubbles(2, "lat3_bubble");
        accept("lat3");

        // stall with no ack holds IF/ID and keeps requesting
        stall = 1'b1; pc_write = 1'b0;
        tick();
        chk_held("stall_fetch_hold");
        chk_req("stall_fetch_req", 1'b1, exp_pc);
        ack = 1'b1; data = instr_of(exp_pc);
        tick();
        ack = 1'b0; data = '0;
        chk_held("hold_enter");
        chk_req("hold_no_req", 1'b0, exp_pc);
        tick();
        chk_held("hold_stay");
        chk_req("hold_no_req2", 1'b0, exp_pc);
        stall = 1'b0; pc_write = 1'b1;
        sb.push_back({exp_pc, instr_of(exp_pc)});
        tick();
        pop_check("hold_release");
        exp_pc = exp_pc + 32'd4;
        chk_req("after_hold_req", 1'b1, exp_pc);

        // flush while request pending: address stable, data discarded on ack
        flush = 1'b1; target = 32'h0000_0100;
        tick();
        flush = 1'b0;
        chk_bubble("flush_pend_bubble");
        chk_req("flush_pend_addr_stable", 1'b1, exp_pc);
        tick();
        chk_bubble("flush_pend_wait");
        chk_req("flush_pend_addr_stable2", 1'b1, exp_pc);
        ack = 1'b1; data = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0; data = '0;
        chk_bubble("flush_pend_discard");
        exp_pc = 32'h0000_0100;
        accept("redirect_100");

        // HOLD entered through pc_write_i alone, then flush wins over stall
        pc_write = 1'b0;
        ack = 1'b1; data = instr_of(exp_pc);
        tick();
        ack = 1'b0; data = '0;
        chk_held("pcw_hold");
        chk_req("pcw_hold_req", 1'b0, exp_pc);
        flush = 1'b1; stall = 1'b1; target = 32'h0000_0200;
        tick();
        flush = 1'b0; stall = 1'b0; pc_write = 1'b1;
        chk_bubble("hold_flush_bubble");
        exp_pc = 32'h0000_0200;
        accept("redirect_200");

        // flush coincident with ack, then PC wrap-around
        flush = 1'b1; target = 32'hFFFF_FFFC; ack = 1'b1; data = 32'h1234_5678;
        tick();
        flush = 1'b0; ack = 1'b0; data = '0;
        chk_bubble("flush_ack_bubble");
        exp_pc = 32'hFFFF_FFFC;
        accept("wrap_top");
        accept("wrap_zero");

        // async reset mid-request
        flush = 1'b1; target = 32'h0000_0020; ack = 1'b1; data = 32'h0;
        tick();
        flush = 1'b0; ack = 1'b0;
        chk_bubble("redirect_20_bubble");
        chk_req("req_at_20", 1'b1, 32'h0000_0020);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_req("midreq_reset_req", 1'b0, 32'h0);
        last_pc = '0;
        chk_bubble("midreq_reset_ifid");
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        sb.delete();
        tick();
        exp_pc = 32'h0;
        accept("restart");
        accept("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that drives the IF/ID pipeline register directly upstream of the load-use hazard detection unit's consumers. It owns the PC register, issues requests to a variable-latency instruction memory over a req/ack handshake, and produces the IF/ID outputs (pc, instr, valid). It honours the HDU's stall/PC-write controls and the ID-stage branch flush/redirect, with a one-entry buffer holding a fetched instruction while IF/ID is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding driven on ifid_instr_o (addi x0,x0,0)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  level; fetching begins when high
pc_write_i  input  1  from HDU; 0 = hold PC
stall_i  input  1  from HDU; 1 = hold IF/ID contents
flush_i  input  1  branch taken in ID; squash IF, redirect PC
branch_target_i  input  32  redirect address, valid with flush_i
imem_req_o  output  1  instruction memory request
imem_addr_o  output  32  request address; stable while imem_req_o high until ack
imem_ack_i  input  1  one-cycle pulse; imem_data_i valid same cycle
imem_data_i  input  32  fetched instruction
ifid_pc_o  output  32  PC of instruction in IF/ID
ifid_instr_o  output  32  instruction in IF/ID
ifid_valid_o  output  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (rst_i low, async): state IDLE, pc_q=RESET_PC, redirect_pend=0, skid empty, imem_req_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0.
- hold = stall_i | ~pc_write_i (the HDU drives them complementary; either one alone also holds).
- imem_addr_o = pc_q always; imem_req_o = 1 only in FETCH.
- IDLE: no requests; go FETCH when start_i=1. start_i dropping later has no effect.
- FETCH, ack=1:
  - flush_i=1 or redirect_pend=1: discard data; pc_q <= (flush_i ? branch_target_i : pend_target); redirect_pend <= 0; IF/ID <= bubble; stay FETCH.
  - else hold=1: data -> skid {pc_q, imem_data_i}; IF/ID unchanged; go HOLD.
  - else: IF/ID <= {pc_q, imem_data_i, valid=1}; pc_q <= pc_q + 4; stay FETCH.
- FETCH, ack=0:
  - flush_i=1: redirect_pend <= 1, pend_target <= branch_target_i (address must not change mid-request); IF/ID <= bubble.
  - else hold=1: IF/ID unchanged.
  - else: IF/ID <= bubble (memory latency inserts bubbles).
- HOLD (imem_req_o=0):
  - flush_i=1: drop skid; pc_q <= branch_target_i; IF/ID <= bubble; go FETCH.
  - else hold=1: stay; IF/ID and skid unchanged.
  - else: IF/ID <= skid with valid=1; pc_q <= pc_q + 4; go FETCH.
- flush_i has priority over hold in all states.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. No misalignment check; branch_target_i is loaded as given.
- Bubble = {ifid_pc_o unchanged, NOP_INSTR, valid=0}.
- Throughput: 1 instruction/cycle when memory acks every cycle and nothing holds.
- Reset asserted mid-request drops the request at once; the memory must tolerate an abandoned request.

Decomposition:
- Shared package: NOP_INSTR, the RESET_PC default, FSM state encoding (IDLE/FETCH/HOLD), and the 32-bit PC width constant.
- One natural sub-module: fetch_skid_buf, a 1-entry {pc, instr} holding register with load/clear/valid.

Test Plan:
- Reset, start_i=1, memory acks every cycle -> addresses 0,4,8,C issued on consecutive cycles; ifid_valid_o=1 from the cycle after the first ack; ifid_pc_o follows 0,4,8.
- 3-cycle memory latency -> two bubbles (valid=0, instr=32'h13) between instructions; imem_addr_o stays stable until ack.
- Ack at pc=8 while stall_i=1/pc_write_i=0 for 2 cycles -> IF/ID holds pc=4; no new request; on release IF/ID=pc 8, next request 0xC.
- flush_i with target 0x100 while a request at 0x10 is pending -> on ack the data is discarded, IF/ID shows a bubble, next request 0x100.
- flush_i and stall_i both high in HOLD -> skid dropped, IF/ID bubble, fetch resumes at the target.
- rst_i pulled low mid-request at pc=0x20 -> outputs return to reset values at once; after release and start_i=1, fetch restarts at RESET_PC.
